// File: rtl/vx_dotp_pkg.sv
// +----------------------------------------------------------------------------+
// | vx_dotp_pkg: types and arithmetic helpers for the packed dot-product unit  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package vx_dotp_pkg;

  typedef enum logic [1:0] {
    W8   = 2'b00,
    W16  = 2'b01,
    W4   = 2'b10,
    WRSV = 2'b11
  } dotp_width_e;

  typedef struct packed {
    logic        is_unsigned;
    dotp_width_e width;
  } dotp_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dotp_state_e;

  function automatic int elem_count(dotp_width_e width);
    case (width)
      W4:      return 8;
      W8:      return 4;
      W16:     return 2;
      default: return 0;
    endcase
  endfunction

  // Element idx of a packed word, extended to 17 bits (wide enough for uint16).
  function automatic logic signed [16:0] elem_ext(logic [31:0] word, int idx,
                                                  dotp_width_e width, logic is_unsigned);
    int          bits;
    logic [15:0] raw;
    logic [16:0] val;
    if (elem_count(width) == 0) return '0;
    bits = 32 / elem_count(width);
    raw  = 16'((word >> (idx * bits)) & ((32'd1 << bits) - 32'd1));
    val  = {1'b0, raw};
    if (!is_unsigned && raw[bits-1]) val = val - (17'd1 << bits);
    return signed'(val);
  endfunction

  function automatic logic signed [63:0] dot_sum(logic [31:0] a, logic [31:0] b,
                                                 dotp_width_e width, logic is_unsigned);
    logic signed [63:0] sum;
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < elem_count(width)) begin
        ea  = elem_ext(a, i, width, is_unsigned);
        eb  = elem_ext(b, i, width, is_unsigned);
        sum = sum + ea * eb;
      end
    end
    return sum;
  endfunction

  function automatic logic signed [63:0] acc_ext(logic [31:0] c, logic zext);
    return zext ? {32'd0, c} : {{32{c[31]}}, c};
  endfunction

  function automatic logic [31:0] sat32(logic signed [63:0] s, logic is_unsigned);
    if (is_unsigned) begin
      if (s < 0) return 32'h0000_0000;
      if (s > 64'sh0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
    end else begin
      if (s > 64'sh0000_0000_7FFF_FFFF) return 32'h7FFF_FFFF;
      if (s < 64'shFFFF_FFFF_8000_0000) return 32'h8000_0000;
    end
    return s[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/vx_alu_dotp_acc_if.sv
// +----------------------------------------------------------------------------+
// | vx_alu_dotp_acc_if: request/commit handshake bundle for vx_alu_dotp_acc    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface vx_alu_dotp_acc_if #(
  parameter int NUM_LANES = 4,
  parameter int TAG_WIDTH = 64
);
  logic                   valid_in;
  logic                   ready_in;
  logic [2:0]             mode_in;
  logic                   acc_en_in;
  logic [NUM_LANES*32-1:0] rs1_in;
  logic [NUM_LANES*32-1:0] rs2_in;
  logic [NUM_LANES*32-1:0] rs3_in;
  logic [TAG_WIDTH-1:0]   tag_in;
  logic                   valid_out;
  logic                   ready_out;
  logic [NUM_LANES*32-1:0] data_out;
  logic [TAG_WIDTH-1:0]   tag_out;

  modport master (
    output valid_in, mode_in, acc_en_in, rs1_in, rs2_in, rs3_in, tag_in, ready_out,
    input  ready_in, valid_out, data_out, tag_out
  );

  modport slave (
    input  valid_in, mode_in, acc_en_in, rs1_in, rs2_in, rs3_in, tag_in, ready_out,
    output ready_in, valid_out, data_out, tag_out
  );
endinterface

`default_nettype wire

// File: rtl/vx_dotp_pe.sv
// +----------------------------------------------------------------------------+
// | vx_dotp_pe: one-lane int4/int8/int16 multiply-sum-accumulate, LATENCY deep |
// | Optional macro VX_DOT_SAT_EN adds a clamping stage. Revision: 1.0          |
// +----------------------------------------------------------------------------+
`default_nettype none

module vx_dotp_pe
  import vx_dotp_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int BATCH_W = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  input  logic [BATCH_W-1:0] req_batch,
  input  dotp_mode_t         req_mode,
  input  logic               req_acc_en,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  input  logic [31:0]        c,
  output logic               res_valid,
  output logic [BATCH_W-1:0] res_batch,
  output logic [31:0]        res_data
);

`ifdef VX_DOT_SAT_EN
  localparam int SUM_W = 64;
  logic w_acc_zext;
  assign w_acc_zext = req_mode.is_unsigned;
`else
  // Wrapping result only needs the low word; modular arithmetic keeps it exact.
  localparam int SUM_W = 32;
  logic w_acc_zext;
  assign w_acc_zext = 1'b0;
`endif

  logic [SUM_W-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    if (req_mode.width != WRSV) begin
      w_sum = SUM_W'(dot_sum(a, b, req_mode.width, req_mode.is_unsigned));
      if (req_acc_en) w_sum = w_sum + SUM_W'(acc_ext(c, w_acc_zext));
    end
  end

  logic [LATENCY-1:0] r_valid;
  logic [BATCH_W-1:0] r_batch [LATENCY];
  logic [SUM_W-1:0]   r_sum   [LATENCY];
`ifdef VX_DOT_SAT_EN
  logic [LATENCY-1:0] r_uns;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
`ifdef VX_DOT_SAT_EN
      r_uns   <= '0;
`endif
      for (int i = 0; i < LATENCY; i++) begin
        r_batch[i] <= '0;
        r_sum[i]   <= '0;
      end
    end else begin
      r_valid[0] <= req_valid;
      r_batch[0] <= req_batch;
      r_sum[0]   <= w_sum;
`ifdef VX_DOT_SAT_EN
      r_uns[0]   <= req_mode.is_unsigned;
`endif
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_batch[i] <= r_batch[i-1];
        r_sum[i]   <= r_sum[i-1];
`ifdef VX_DOT_SAT_EN
        r_uns[i]   <= r_uns[i-1];
`endif
      end
    end
  end

`ifdef VX_DOT_SAT_EN
  logic               r_sat_valid;
  logic [BATCH_W-1:0] r_sat_batch;
  logic [31:0]        r_sat_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sat_valid <= 1'b0;
      r_sat_batch <= '0;
      r_sat_data  <= '0;
    end else begin
      r_sat_valid <= r_valid[LATENCY-1];
      r_sat_batch <= r_batch[LATENCY-1];
      r_sat_data  <= sat32($signed(r_sum[LATENCY-1]), r_uns[LATENCY-1]);
    end
  end

  assign res_valid = r_sat_valid;
  assign res_batch = r_sat_batch;
  assign res_data  = r_sat_data;
`else
  assign res_valid = r_valid[LATENCY-1];
  assign res_batch = r_batch[LATENCY-1];
  assign res_data  = r_sum[LATENCY-1];
`endif

endmodule

`default_nettype wire

// File: rtl/vx_alu_dotp_acc.sv
// +----------------------------------------------------------------------------+
// | vx_alu_dotp_acc: multi-precision packed dot product with rs3 accumulate,   |
// | lanes batched over NUM_PES PEs. Optional macro: VX_DOT_SAT_EN. Rev: 1.0    |
// +----------------------------------------------------------------------------+
`default_nettype none

module vx_alu_dotp_acc
  import vx_dotp_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int NUM_PES   = 2,
  parameter int LATENCY   = 2,
  parameter int TAG_WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  vx_alu_dotp_acc_if.slave bus
);

  localparam int NUM_BATCHES = NUM_LANES / NUM_PES;
  localparam int BATCH_W     = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;
  localparam logic [BATCH_W-1:0] LAST_BATCH = BATCH_W'(NUM_BATCHES - 1);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [1:0] S_DONE  = ST_DONE;

  if (NUM_LANES % NUM_PES != 0) begin : g_bad_lanes
    $error("vx_alu_dotp_acc: NUM_LANES must be a multiple of NUM_PES");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("vx_alu_dotp_acc: LATENCY must be >= 1");
  end

  logic [1:0]              r_state;
  logic [BATCH_W-1:0]      r_batch;
  dotp_mode_t              r_mode;
  logic                    r_acc_en;
  logic [NUM_LANES*32-1:0] r_rs1;
  logic [NUM_LANES*32-1:0] r_rs2;
  logic [NUM_LANES*32-1:0] r_rs3;
  logic [NUM_LANES*32-1:0] r_result;
  logic [TAG_WIDTH-1:0]    r_tag;

  logic                    w_accept;
  logic                    w_issue;
  logic [NUM_PES-1:0]      w_res_valid;
  logic [BATCH_W-1:0]      w_res_batch [NUM_PES];
  logic [31:0]             w_res_data  [NUM_PES];

  assign bus.ready_in  = reset_n && (r_state == S_IDLE);
  assign bus.valid_out = (r_state == S_DONE);
  assign bus.data_out  = r_result;
  assign bus.tag_out   = r_tag;
  assign w_accept      = bus.valid_in && bus.ready_in;
  assign w_issue       = (r_state == S_ISSUE);

  for (genvar p = 0; p < NUM_PES; p++) begin : g_pe
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_c;

    assign w_a = r_rs1[(int'(r_batch) * NUM_PES + p) * 32 +: 32];
    assign w_b = r_rs2[(int'(r_batch) * NUM_PES + p) * 32 +: 32];
    assign w_c = r_rs3[(int'(r_batch) * NUM_PES + p) * 32 +: 32];

    vx_dotp_pe #(
      .LATENCY (LATENCY),
      .BATCH_W (BATCH_W)
    ) u_pe (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (w_issue),
      .req_batch  (r_batch),
      .req_mode   (r_mode),
      .req_acc_en (r_acc_en),
      .a          (w_a),
      .b          (w_b),
      .c          (w_c),
      .res_valid  (w_res_valid[p]),
      .res_batch  (w_res_batch[p]),
      .res_data   (w_res_data[p])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_batch  <= '0;
      r_mode   <= '0;
      r_acc_en <= 1'b0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rs3    <= '0;
      r_tag    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mode   <= dotp_mode_t'(bus.mode_in);
            r_acc_en <= bus.acc_en_in;
            r_rs1    <= bus.rs1_in;
            r_rs2    <= bus.rs2_in;
            r_rs3    <= bus.rs3_in;
            r_tag    <= bus.tag_in;
            r_batch  <= '0;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_batch == LAST_BATCH) r_state <= S_DRAIN;
          else                       r_batch <= r_batch + 1'b1;
        end
        S_DRAIN: begin
          // All PEs move in lockstep, so PE 0 alone marks the final batch exit.
          if (w_res_valid[0] && (w_res_batch[0] == LAST_BATCH)) r_state <= S_DONE;
        end
        S_DONE: begin
          if (bus.ready_out) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result <= '0;
    end else begin
      for (int p = 0; p < NUM_PES; p++) begin
        if (w_res_valid[p])
          r_result[(int'(w_res_batch[p]) * NUM_PES + p) * 32 +: 32] <= w_res_data[p];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vx_alu_dotp_acc.sv
// +----------------------------------------------------------------------------+
// | tb_vx_alu_dotp_acc: scoreboard bench with directed and random operations   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_vx_alu_dotp_acc;

  localparam int NL  = 4;
  localparam int NP  = 2;
  localparam int LAT = 2;
  localparam int TW  = 64;
  localparam int NB  = NL / NP;
`ifdef VX_DOT_SAT_EN
  localparam int EXP_LAT = NB + LAT + 1;
`else
  localparam int EXP_LAT = NB + LAT;
`endif

  typedef struct {
    logic [NL*32-1:0] data;
    logic [TW-1:0]    tag;
    int               acc_edge;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   cyc;
  int   rdy_mode;
  exp_t sb[$];

  vx_alu_dotp_acc_if #(.NUM_LANES(NL), .TAG_WIDTH(TW)) bus ();

  vx_alu_dotp_acc #(
    .NUM_LANES (NL),
    .NUM_PES   (NP),
    .LATENCY   (LAT),
    .TAG_WIDTH (TW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.ready_out = 1'b1;
      1:       bus.ready_out = 1'($urandom_range(0, 1));
      default: bus.ready_out = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: split into 32/w elements, extend, sum exactly, then wrap or clamp.
  function automatic logic [31:0] lane_ref(logic [2:0] mode, logic acc,
                                           logic [31:0] a, logic [31:0] b, logic [31:0] c);
    int     w;
    longint sum, ea, eb;
    case (mode[1:0])
      2'b00:   w = 8;
      2'b01:   w = 16;
      2'b10:   w = 4;
      default: return 32'h0;
    endcase
    sum = 0;
    for (int e = 0; e < 32 / w; e++) begin
      ea = longint'((a >> (e * w)) & ((32'h1 << w) - 1));
      eb = longint'((b >> (e * w)) & ((32'h1 << w) - 1));
      if (!mode[2] && ea >= (longint'(1) << (w - 1))) ea -= (longint'(1) << w);
      if (!mode[2] && eb >= (longint'(1) << (w - 1))) eb -= (longint'(1) << w);
      sum += ea * eb;
    end
`ifdef VX_DOT_SAT_EN
    if (acc) sum += mode[2] ? longint'(c) : longint'($signed(c));
    if (mode[2]) begin
      if (sum > 64'sh0FFFF_FFFF) sum = 64'sh0FFFF_FFFF;
      if (sum < 0) sum = 0;
    end else begin
      if (sum > 64'sh07FFF_FFFF) sum = 64'sh07FFF_FFFF;
      if (sum < -64'sh08000_0000) sum = -64'sh08000_0000;
    end
`else
    if (acc) sum += longint'($signed(c));
`endif
    return sum[31:0];
  endfunction

  function automatic logic [NL*32-1:0] model(logic [2:0] mode, logic acc, logic [NL*32-1:0] a,
                                             logic [NL*32-1:0] b, logic [NL*32-1:0] c);
    logic [NL*32-1:0] r;
    for (int l = 0; l < NL; l++)
      r[l*32 +: 32] = lane_ref(mode, acc, a[l*32 +: 32], b[l*32 +: 32], c[l*32 +: 32]);
    return r;
  endfunction

  function automatic logic [NL*32-1:0] rep(logic [31:0] w);
    logic [NL*32-1:0] r;
    for (int l = 0; l < NL; l++) r[l*32 +: 32] = w;
    return r;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_8000;
      1:       return 32'h7FFF_7FFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8888_8888;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [NL*32-1:0] rand_vec();
    logic [NL*32-1:0] r;
    for (int l = 0; l < NL; l++) r[l*32 +: 32] = rand_word();
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic do_op(input logic [2:0] mode, input logic acc, input logic [NL*32-1:0] a,
                       input logic [NL*32-1:0] b, input logic [NL*32-1:0] c,
                       input logic [NL*32-1:0] exp);
    bit   accepted;
    exp_t e;
    bus.valid_in  = 1'b1;
    bus.mode_in   = mode;
    bus.acc_en_in = acc;
    bus.rs1_in    = a;
    bus.rs2_in    = b;
    bus.rs3_in    = c;
    bus.tag_in    = {$urandom, $urandom};
    accepted = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (bus.ready_in) begin
        accepted = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got ready_in=0 expected ready_in=1");
    end else begin
      e.data     = exp;
      e.tag      = bus.tag_in;
      e.acc_edge = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    bus.rs1_in   = rand_vec();
    bus.tag_in   = {$urandom, $urandom};
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_queue_empty", 256'(sb.size()), 256'd0);
  endtask

  // Monitor: latency on rise, stability while stalled, compare on commit.
  bit               prev_v, prev_hs;
  logic [NL*32-1:0] held_d;
  logic [TW-1:0]    held_t;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_v  = 0;
      prev_hs = 0;
    end else begin
      if (bus.valid_out) begin
        check("ready_in_low_in_done", 256'(bus.ready_in), 256'd0);
        if (prev_v && !prev_hs) begin
          check("data_stable", 256'(bus.data_out), 256'(held_d));
          check("tag_stable", 256'(bus.tag_out), 256'(held_t));
        end else begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid_out: got valid_out=1 expected valid_out=0");
          end else begin
            check("latency", 256'(cyc - sb[0].acc_edge), 256'(EXP_LAT));
          end
          held_d = bus.data_out;
          held_t = bus.tag_out;
        end
        if (bus.ready_out && sb.size() != 0) begin
          e = sb.pop_front();
          check("data_out", 256'(bus.data_out), 256'(e.data));
          check("tag_out", 256'(bus.tag_out), 256'(e.tag));
        end
      end
      prev_v  = bus.valid_out;
      prev_hs = bus.valid_out && bus.ready_out;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NL*32-1:0] a, b, c;
    logic [2:0]       m;
    logic             acc;
    int               n;
    checks        = 0;
    failures      = 0;
    rdy_mode      = 0;
    reset_n       = 1'b0;
    bus.valid_in  = 1'b0;
    bus.mode_in   = 3'b000;
    bus.acc_en_in = 1'b0;
    bus.rs1_in    = '0;
    bus.rs2_in    = '0;
    bus.rs3_in    = '0;
    bus.tag_in    = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_out", 256'(bus.valid_out), 256'd0);
    check("rst_ready_in", 256'(bus.ready_in), 256'd0);
    check("rst_data_out", 256'(bus.data_out), 256'd0);
    check("rst_tag_out", 256'(bus.tag_out), 256'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ready_in", 256'(bus.ready_in), 256'd1);

    // Directed arithmetic cases
    do_op(3'b000, 1'b0, rep(32'h0102_03FF), rep(32'h0101_0101), rep(32'd0), rep(32'h0000_0005));
    do_op(3'b100, 1'b0, rep(32'h0102_03FF), rep(32'h0101_0101), rep(32'd0), rep(32'h0000_0105));
    do_op(3'b000, 1'b1, rep(32'h0102_03FF), rep(32'h0101_0101), rep(32'd100), rep(32'h0000_0069));
    do_op(3'b001, 1'b0, rep(32'h0002_FFFF), rep(32'h0003_0004), rep(32'd0), rep(32'h0000_0002));
    do_op(3'b110, 1'b0, rep(32'h1111_1111), rep(32'h7777_7777), rep(32'd0), rep(32'h0000_0038));
`ifdef VX_DOT_SAT_EN
    do_op(3'b001, 1'b0, rep(32'h8000_8000), rep(32'h8000_8000), rep(32'd0), rep(32'h7FFF_FFFF));
`else
    do_op(3'b001, 1'b0, rep(32'h8000_8000), rep(32'h8000_8000), rep(32'd0), rep(32'h8000_0000));
`endif
    do_op(3'b011, 1'b1, rand_vec(), rand_vec(), rep(32'd12345), rep(32'd0));
    do_op(3'b111, 1'b0, rand_vec(), rand_vec(), rand_vec(), rep(32'd0));
    wait_drain();

    // Backpressure: distinct lanes, DONE stalled over 10 cycles, pulse on valid_in
    rdy_mode = 2;
    a = rand_vec(); b = rand_vec(); c = rand_vec();
    do_op(3'b000, 1'b1, a, b, c, model(3'b000, 1'b1, a, b, c));
    n = 0;
    while (!bus.valid_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_reached_done", 256'(bus.valid_out), 256'd1);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b1;
    @(negedge clk);
    check("no_accept_in_done", 256'(bus.ready_in), 256'd0);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rdy_mode = 0;
    wait_drain();
    do_op(3'b100, 1'b0, rep(32'h0102_03FF), rep(32'h0101_0101), rep(32'd0), rep(32'h0000_0105));
    wait_drain();

    // Reset during ISSUE drops the operation
    bus.valid_in  = 1'b1;
    bus.mode_in   = 3'b000;
    bus.acc_en_in = 1'b0;
    bus.rs1_in    = rand_vec();
    bus.rs2_in    = rand_vec();
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_valid_out", 256'(bus.valid_out), 256'd0);
    check("midrst_ready_in", 256'(bus.ready_in), 256'd0);
    check("midrst_data_out", 256'(bus.data_out), 256'd0);
    check("midrst_tag_out", 256'(bus.tag_out), 256'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    do_op(3'b000, 1'b1, rep(32'h0102_03FF), rep(32'h0101_0101), rep(32'd100), rep(32'h0000_0069));
    wait_drain();

    // Random operations with random commit backpressure
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      m   = 3'($urandom_range(0, 7));
      acc = 1'($urandom_range(0, 1));
      a = rand_vec(); b = rand_vec(); c = rand_vec();
      do_op(m, acc, a, b, c, model(m, acc, a, b, c));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vx_alu_dotp_acc.md
Name: vx_alu_dotp_acc

Overview:
Multi-precision packed dot-product unit with accumulate for the ALU execute stage. It is the parametrised successor to the fixed int8 dot unit and adds three capabilities: a selectable element width (int4/int8/int16), signed or unsigned operands, and an optional rs3 accumulate. NUM_LANES lanes are time-multiplexed over NUM_PES pipelined PEs by an internal batch FSM. The full lane vector and its tag are returned through a valid/ready commit handshake.

Parameters:
NUM_LANES, 4, lanes per instruction; must be a multiple of NUM_PES.
NUM_PES, 2, physical dot-product PEs; NUM_BATCHES = NUM_LANES/NUM_PES.
LATENCY, 2, PE pipeline depth in cycles; must be >= 1.
TAG_WIDTH, 64, opaque tag bits (uuid/wid/tmask/PC/rd/wb/pid/sop/eop) carried through the block.

Ports:
clk  in  1  clock.
reset_n  in  1  asynchronous, active-low reset.
valid_in  in  1  request valid.
ready_in  out  1  request accepted when valid_in && ready_in.
mode_in  in  3  [1:0] element width (00 int8, 01 int16, 10 int4, 11 reserved); [2] unsigned.
acc_en_in  in  1  add rs3 to the lane result.
rs1_in  in  NUM_LANES*32  packed operand A, one word per lane.
rs2_in  in  NUM_LANES*32  packed operand B, one word per lane.
rs3_in  in  NUM_LANES*32  accumulator, one word per lane.
tag_in  in  TAG_WIDTH  opaque tag.
valid_out  out  1  result valid.
ready_out  in  1  commit backpressure.
data_out  out  NUM_LANES*32  per-lane result.
tag_out  out  TAG_WIDTH  tag captured at accept.

Behaviour:
- Reset (async, reset_n low): FSM to IDLE; valid_out=0, ready_in=0 while reset_n is low, data_out=0, tag_out=0; PE pipeline valids cleared. Reset mid-operation drops the instruction with no output.
- FSM states:
  - IDLE: ready_in=1. On accept, register mode, acc_en, rs1/2/3 and tag, then go to ISSUE.
  - ISSUE: feed batch k (lanes k*NUM_PES .. k*NUM_PES+NUM_PES-1) to the PEs, one batch per cycle, k = 0..NUM_BATCHES-1. After the last batch go to DRAIN.
  - DRAIN: wait for the last batch to exit the PE pipeline, then go to DONE.
  - DONE: valid_out=1, data_out and tag_out held stable. On ready_out, go to IDLE.
- Only one instruction is in flight; ready_in=0 outside IDLE. No accept in the same cycle as the DONE handshake.
- Latency: valid_out rises exactly NUM_BATCHES+LATENCY cycles after the accept edge. Backpressure only stretches DONE.
- The PE pipeline advances every cycle. A per-stage valid bit plus batch index steers each result into the lane result register.
- Arithmetic per lane:
  - Split A and B into N = 32/w elements (w = 4, 8 or 16), element 0 at the LSBs.
  - Extend each element signed or unsigned according to mode[2].
  - Sum the N products in 64-bit precision; add sign-extended rs3 when acc_en.
  - Result is the low 32 bits (wraps modulo 2^32).
- mode[1:0]=11: every lane result is 0 and the handshake is unaffected.
- NUM_PES==NUM_LANES: a single batch, and ISSUE lasts one cycle.
- NUM_LANES % NUM_PES != 0: elaboration-time $error.

Optional Feature:
VX_DOT_SAT_EN
- Defined: the 64-bit sum is clamped instead of wrapped.
  - Signed modes clamp to [0x80000000, 0x7FFFFFFF].
  - Unsigned modes clamp to [0, 0xFFFFFFFF]; rs3 is treated as unsigned.
  - Adds one PE pipeline stage, so total latency is NUM_BATCHES+LATENCY+1.
- Undefined: results wrap modulo 2^32 and latency is as stated above.

Decomposition:
- Package vx_dotp_pkg:
  - dotp_width_e enum {W8, W16, W4, WRSV}.
  - mode struct {unsigned, width}.
  - ELEM_COUNT function of width.
  - State enum {IDLE, ISSUE, DRAIN, DONE}.
- One sub-module, vx_dotp_pe: a single-lane multi-precision multiply-sum-accumulate with its LATENCY-deep pipeline and the optional saturation stage, instanced NUM_PES times.
- The FSM, batch counter and result/tag registers stay in the top module.

Test Plan:
- int8 signed, rs1=0x010203FF, rs2=0x01010101, acc off -> lane result 0x00000005; valid_out exactly NUM_BATCHES+LATENCY cycles (4 at defaults) after accept.
- Same operands, mode unsigned -> 0x00000105 (261); int8 signed with acc_en and rs3=100 -> 0x00000069.
- int16 signed, rs1=0x0002FFFF, rs2=0x00030004 -> 0x00000002; int4 unsigned, rs1=0x11111111, rs2=0x77777777 -> 0x00000038.
- int16 signed, rs1=rs2=0x80008000 -> 0x80000000 without VX_DOT_SAT_EN, 0x7FFFFFFF with it; reserved mode 11 -> 0 on all lanes.
- Distinct per-lane operands with ready_out held low for 10 cycles in DONE -> data_out and tag_out stable; ready_in=0 throughout; a valid_in pulse in DONE is not accepted; after ready_out, next accept in IDLE.
- Drive reset_n low during ISSUE, then release and issue a new op -> no valid_out from the dropped op; the new op returns a correct result at nominal latency.
